// File: rtl/cga_line_doubler.sv
// cga_line_doubler: scan doubler between the CGA core and the VGA output path.
// Each incoming IRGB line (pixel every other clk) is captured into one half of
// a ping-pong buffer while the other half is replayed twice at full clk rate.
// Optional build macro CGA_SCANLINE_DIM_EN: second replay of every line has
// its intensity bit cleared, giving a dimmed-scanline look.
module cga_line_doubler #(
  parameter int LINE_LEN  = 1024,
  parameter int ADDR_W    = 10,
  parameter int HSYNC_LEN = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_reset,
  input  logic [3:0] video,
  output logic [3:0] dbl_video,
  output logic       dbl_hsync,
  output logic       dbl_pass
);

  localparam logic [ADDR_W-1:0] WR_LAST = ADDR_W'(LINE_LEN - 1);
  localparam int HS_W = $clog2(HSYNC_LEN + 1);
  localparam logic [HS_W-1:0] HS_RELOAD = HS_W'(HSYNC_LEN - 1);

  typedef enum logic [1:0] {IDLE, PASS0, PASS1} rd_state_t;

  logic [3:0]        line_mem [2*LINE_LEN];
  logic              phase;
  logic              wr_buf;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] saved_len;
  logic              rd_buf;
  rd_state_t         state;
  rd_state_t         state_next;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_addr_next;
  logic [ADDR_W-1:0] rd_last;
  logic              wr_strobe;
  logic              wr_en;
  logic [3:0]        rd_data;
  logic              s1_active;
  logic              s1_pass;
  logic              s1_start;
  logic [3:0]        out_pix;
  logic [HS_W-1:0]   hsync_cnt;

  // line_reset beats a coincident strobe; the last buffer slot is never written
  assign wr_strobe = phase & ~line_reset;
  assign wr_en     = wr_strobe & (wr_addr != WR_LAST);
  assign rd_last   = saved_len - ADDR_W'(1);

  // Line buffer RAM: write port on the capture side, registered read port
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      line_mem[{wr_buf, wr_addr}] <= video;
    end
    rd_data <= line_mem[{rd_buf, rd_addr}];
  end

  // Capture side: strobe phase, saturating write address, buffer swap on line_reset
  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= 1'b0;
      wr_buf    <= 1'b0;
      wr_addr   <= '0;
      saved_len <= '0;
      rd_buf    <= 1'b0;
    end else if (line_reset) begin
      phase     <= 1'b1;
      saved_len <= wr_addr;
      wr_buf    <= ~wr_buf;
      rd_buf    <= wr_buf;
      wr_addr   <= '0;
    end else begin
      phase <= ~phase;
      if (wr_en) begin
        wr_addr <= wr_addr + ADDR_W'(1);
      end
    end
  end

  // Replay FSM state and read address registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rd_addr <= '0;
    end else begin
      state   <= state_next;
      rd_addr <= rd_addr_next;
    end
  end

  // Replay FSM next state: two passes per line, any line_reset restarts from PASS0
  always_comb begin
    state_next   = state;
    rd_addr_next = rd_addr;
    if (line_reset) begin
      rd_addr_next = '0;
      state_next   = (wr_addr == '0) ? IDLE : PASS0;
    end else begin
      case (state)
        PASS0: begin
          if (rd_addr == rd_last) begin
            rd_addr_next = '0;
            state_next   = PASS1;
          end else begin
            rd_addr_next = rd_addr + ADDR_W'(1);
          end
        end
        PASS1: begin
          if (rd_addr == rd_last) begin
            rd_addr_next = '0;
            state_next   = IDLE;
          end else begin
            rd_addr_next = rd_addr + ADDR_W'(1);
          end
        end
        default: begin
          rd_addr_next = '0;
          state_next   = IDLE;
        end
      endcase
    end
  end

  // Stage 1: carry pass/activity flags alongside the RAM read
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_active <= 1'b0;
      s1_pass   <= 1'b0;
      s1_start  <= 1'b0;
    end else begin
      s1_active <= (state != IDLE);
      s1_pass   <= (state == PASS1);
      s1_start  <= (state != IDLE) && (rd_addr == '0);
    end
  end

  // Pixel seen on the output for the current pass
  always_comb begin
`ifdef CGA_SCANLINE_DIM_EN
    out_pix = s1_pass ? {1'b0, rd_data[2:0]} : rd_data;
`else
    out_pix = rd_data;
`endif
  end

  // Stage 2: output register, blanking while idle, hsync pulse retriggered at each pass start
  always_ff @(posedge clk) begin
    if (reset) begin
      dbl_video <= 4'h0;
      dbl_pass  <= 1'b0;
      dbl_hsync <= 1'b0;
      hsync_cnt <= '0;
    end else begin
      dbl_video <= s1_active ? out_pix : 4'h0;
      dbl_pass  <= s1_active & s1_pass;
      if (s1_start) begin
        dbl_hsync <= 1'b1;
        hsync_cnt <= HS_RELOAD;
      end else if (hsync_cnt != '0) begin
        dbl_hsync <= 1'b1;
        hsync_cnt <= hsync_cnt - HS_W'(1);
      end else begin
        dbl_hsync <= 1'b0;
      end
    end
  end

endmodule
